// File: rtl/score_frame_accum.sv
// score_frame_accum: accumulates FRAME_LEN unsigned score samples into a
// saturating sum, peak and sticky saturation flag, then holds the result
// behind a valid/ready handshake.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   clear                 synchronous abort of partial frame / held result
//   in_valid, in_ready    sample handshake (in_ready depends on state only)
//   in_data [W]           unsigned score sample
//   out_valid, out_ready  result handshake
//   out_sum [ACC_W]       saturating frame sum
//   out_peak [W]          largest sample of the frame
//   out_sat               sum saturated during the frame
module score_frame_accum #(
  parameter int unsigned W         = 8,
  parameter int unsigned FRAME_LEN = 8,
  parameter int unsigned ACC_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [W-1:0]     out_peak,
  output logic             out_sat
);

  localparam int unsigned CNT_W = $clog2(FRAME_LEN + 1);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t             state, state_d;
  logic [CNT_W-1:0]   count, count_d;
  logic [ACC_W-1:0]   sum, sum_d;
  logic [W-1:0]       peak, peak_d;
  logic               sat, sat_d;
  logic [ACC_W-1:0]   out_sum_d;
  logic [W-1:0]       out_peak_d;
  logic               out_sat_d;
  logic               accept;
  logic [ACC_W:0]     sum_ext;
  logic [ACC_W-1:0]   sum_acc;
  logic [W-1:0]       peak_acc;
  logic [CNT_W-1:0]   count_inc;

  // in_ready is a registered decode of state, so accept never depends on out_ready
  assign accept    = in_valid & in_ready;
  // Top bit of the widened add flags overflow of the ACC_W-bit sum
  assign sum_ext   = {1'b0, sum} + (ACC_W + 1)'(in_data);
  assign sum_acc   = sum_ext[ACC_W] ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
  assign peak_acc  = (in_data > peak) ? in_data : peak;
  assign count_inc = count + CNT_W'(1);

  // Next-state and datapath update
  always_comb begin
    state_d    = state;
    count_d    = count;
    sum_d      = sum;
    peak_d     = peak;
    sat_d      = sat;
    out_sum_d  = out_sum;
    out_peak_d = out_peak;
    out_sat_d  = out_sat;

    if (clear) begin
      state_d = IDLE;
      count_d = '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            sum_d   = ACC_W'(in_data);
            peak_d  = in_data;
            count_d = CNT_W'(1);
            sat_d   = 1'b0;
            state_d = ACCUM;
          end
        end
        ACCUM: begin
          if (accept) begin
            sum_d   = sum_acc;
            peak_d  = peak_acc;
            sat_d   = sat | sum_ext[ACC_W];
            count_d = count_inc;
            if (count_inc == CNT_W'(FRAME_LEN)) begin
              state_d    = HOLD;
              out_sum_d  = sum_acc;
              out_peak_d = peak_acc;
              out_sat_d  = sat | sum_ext[ACC_W];
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_d = IDLE;
            count_d = '0;
          end
        end
        default: begin
          state_d = IDLE;
          count_d = '0;
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      count     <= '0;
      sum       <= '0;
      peak      <= '0;
      sat       <= 1'b0;
      out_sum   <= '0;
      out_peak  <= '0;
      out_sat   <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      state     <= state_d;
      count     <= count_d;
      sum       <= sum_d;
      peak      <= peak_d;
      sat       <= sat_d;
      out_sum   <= out_sum_d;
      out_peak  <= out_peak_d;
      out_sat   <= out_sat_d;
      out_valid <= (state_d == HOLD);
      in_ready  <= (state_d != HOLD);
    end
  end

endmodule

// File: tb/tb_score_frame_accum.sv
// tb_score_frame_accum: directed and randomized frames applied to two
// instances (ACC_W = 16 and ACC_W = 8) sharing the same stimulus; results
// are compared against a frame-level reference model.
module tb_score_frame_accum;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        out_ready = 1'b1;

  logic        in_ready_a, out_valid_a, out_sat_a;
  logic [15:0] out_sum_a;
  logic [7:0]  out_peak_a;
  logic        in_ready_b, out_valid_b, out_sat_b;
  logic [7:0]  out_sum_b;
  logic [7:0]  out_peak_b;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  logic [7:0]  smp [8];
  int unsigned h_sum_a, h_sum_b, h_peak;
  int unsigned h_sat_a, h_sat_b;

  always #5 clk = ~clk;

  score_frame_accum #(.W(8), .FRAME_LEN(8), .ACC_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
    .out_valid(out_valid_a), .out_ready(out_ready),
    .out_sum(out_sum_a), .out_peak(out_peak_a), .out_sat(out_sat_a)
  );

  score_frame_accum #(.W(8), .FRAME_LEN(8), .ACC_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
    .out_valid(out_valid_b), .out_ready(out_ready),
    .out_sum(out_sum_b), .out_peak(out_peak_b), .out_sat(out_sat_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Frame-level reference: total of the samples clipped at maxv
  task automatic model(input int unsigned maxv, output int unsigned s,
                       output int unsigned pk, output int unsigned st);
    int unsigned tot;
    tot = 0;
    pk  = 0;
    for (int i = 0; i < 8; i++) begin
      tot += 32'(smp[i]);
      if (32'(smp[i]) > pk) pk = 32'(smp[i]);
    end
    s  = (tot > maxv) ? maxv : tot;
    st = (tot > maxv) ? 1 : 0;
  endtask

  task automatic check_held(input string tag);
    chk({tag, "_sum16"}, 32'(out_sum_a), h_sum_a);
    chk({tag, "_sum8"},  32'(out_sum_b), h_sum_b);
    chk({tag, "_peak"},  32'(out_peak_a), h_peak);
    chk({tag, "_sat16"}, 32'(out_sat_a), h_sat_a);
    chk({tag, "_sat8"},  32'(out_sat_b), h_sat_b);
  endtask

  // Present one sample until it is accepted (bounded)
  task automatic push(input logic [7:0] d);
    bit acc;
    int n;
    in_valid = 1'b1;
    in_data  = d;
    n = 0;
    do begin
      acc = in_ready_a;
      tick();
      n++;
    end while (!acc && n < 20);
    if (!acc) chk("push_timeout", 32'(0), 32'(1));
    in_valid = 1'b0;
  endtask

  task automatic do_frame(input string tag, input bit gap, input int bp);
    int unsigned pk, st;
    out_ready = (bp == 0);
    for (int i = 0; i < 8; i++) begin
      chk({tag, "_nvalid"}, 32'(out_valid_a), 32'(0));
      push(smp[i]);
      if (gap && i < 7) tick();
    end
    model(32'd65535, h_sum_a, pk, h_sat_a);
    model(32'd255, h_sum_b, h_peak, h_sat_b);
    chk({tag, "_valid16"}, 32'(out_valid_a), 32'(1));
    chk({tag, "_valid8"},  32'(out_valid_b), 32'(1));
    chk({tag, "_inrdy_hold"}, 32'(in_ready_a), 32'(0));
    check_held(tag);
    for (int c = 0; c < bp; c++) begin
      tick();
      chk({tag, "_bp_valid"}, 32'(out_valid_a), 32'(1));
      chk({tag, "_bp_inrdy"}, 32'(in_ready_a), 32'(0));
      check_held({tag, "_bp"});
    end
    out_ready = 1'b1;
    tick();
    chk({tag, "_done_valid"}, 32'(out_valid_a), 32'(0));
    chk({tag, "_done_inrdy"}, 32'(in_ready_a), 32'(1));
    check_held({tag, "_after"});
  endtask

  task automatic fill(input logic [7:0] v);
    for (int i = 0; i < 8; i++) smp[i] = v;
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 8; i++) smp[i] = 8'($urandom);
  endtask

  initial begin
    logic [7:0] mix [8];
    h_sum_a = 0; h_sum_b = 0; h_peak = 0; h_sat_a = 0; h_sat_b = 0;

    // Reset values
    #12;
    chk("rst_valid", 32'(out_valid_a), 32'(0));
    chk("rst_inrdy", 32'(in_ready_a), 32'(1));
    check_held("rst");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst_inrdy", 32'(in_ready_a), 32'(1));

    // All 24s streaming
    fill(8'd24);
    do_frame("stream24", 1'b0, 0);

    // Mixed samples
    mix = '{8'd24, 8'd19, 8'd19, 8'd24, 8'd0, 8'd255, 8'd1, 8'd19};
    for (int i = 0; i < 8; i++) smp[i] = mix[i];
    do_frame("mixed", 1'b0, 0);

    // Backpressure
    fill_rand();
    do_frame("bp5", 1'b0, 5);

    // Saturation then recovery
    mix = '{8'd200, 8'd100, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1};
    for (int i = 0; i < 8; i++) smp[i] = mix[i];
    do_frame("sat", 1'b0, 0);
    fill(8'd1);
    do_frame("ones", 1'b0, 0);

    // Clear after three accepts
    for (int i = 0; i < 3; i++) push(8'($urandom_range(100, 255)));
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_valid", 32'(out_valid_a), 32'(0));
    chk("clr_inrdy", 32'(in_ready_a), 32'(1));
    check_held("clr");
    fill_rand();
    do_frame("post_clr", 1'b0, 0);

    // Reset while holding a result
    fill_rand();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(smp[i]);
    chk("hold_valid", 32'(out_valid_a), 32'(1));
    rst_n = 1'b0;
    #2;
    chk("rst_hold_valid", 32'(out_valid_a), 32'(0));
    chk("rst_hold_inrdy", 32'(in_ready_a), 32'(1));
    h_sum_a = 0; h_sum_b = 0; h_peak = 0; h_sat_a = 0; h_sat_b = 0;
    check_held("rst_hold");
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("rst_hold_idle_valid", 32'(out_valid_a), 32'(0));
    fill_rand();
    do_frame("post_rst", 1'b0, 0);

    // Alternating gaps
    fill(8'd24);
    do_frame("gap24", 1'b1, 0);

    // Random frames
    for (int f = 0; f < 8; f++) begin
      fill_rand();
      do_frame("rand", 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
